tsg: RTL
========

// Module: tsg
// PURPOSE
//  Training-sequence generator: the transmit side of the LTSSM TS path, driving Polling TS1/TS2 ordered sets.
//  It builds the 16-symbol TS for the LTSSM state/sub-state in ts_info, streams it on a valid/ready interface
//  and counts accepted TSs. It raises ts_sent_enough, which feeds the analyzer's to_tsa_ts_sent_enough input.
//  Symbol encodings come from define.v (`COM, `PADG12, `D10_2, `D5_2, `POLL, `POLL_ACTIVE, `POLL_CFG, `RATE_SUPPORT).
// PARAMETERS
//  TS1_TARGET  1024  TS1s to send in Polling.Active before ts_sent_enough
//  TS2_TARGET  16    TS2s to send in Polling.Configuration before ts_sent_enough
//  GAP_CYC     0     idle cycles (tx_ts_valid low) inserted after each accepted TS
// PORTS
//  clk             in   1    1GHz system clock; one clock domain
//  rst             in   1    reset, asynchronous, active-high
//  ts_info         in   8    [7:4] LTSSM state, [3:0] sub-state; sampled only when an update is taken
//  ts_update       in   1    level request to load ts_info; held by the controller until ts_update_ack
//  ts_update_ack   out  1    one-cycle pulse: update taken
//  ts_stop         in   1    stop transmitting at the next TS boundary
//  tx_ready        in   1    downstream accepts tx_ts this cycle
//  tx_ts_valid     out  1    tx_ts holds a complete TS
//  tx_ts           out  128  symbol 0 in [127:120] ... symbol 15 in [7:0]
//  ts_sent_enough  out  1    sticky: accepted-TS count >= target for the current context
// BEHAVIOUR
//  - Reset (async): state IDLE, tx_ts=0, tx_ts_valid=0, ts_update_ack=0, ts_sent_enough=0, count=0, gap=0.
//  - States: IDLE, SEND, GAP.
//  - TS content (POLL): sym0=`COM; sym1,2=`PADG12; sym3=8'hFF; sym4={2'b00,`RATE_SUPPORT}; sym5=8'h00.
//    Sym6..15 are `D10_2 (TS1) when the sub-state is `POLL_ACTIVE, otherwise `D5_2 (TS2).
//    Target is TS1_TARGET for `POLL_ACTIVE, otherwise TS2_TARGET.
//  - IDLE, ts_update=1 in cycle N:
//    - N+1: ts_update_ack=1, count=0, ts_sent_enough=0, tx_ts loaded.
//    - State POLL: tx_ts_valid=1 at N+1, enter SEND.
//    - State not POLL: acked, stay IDLE, tx_ts_valid stays 0.
//  - Handshake: once asserted, tx_ts_valid and tx_ts stay stable until tx_valid&tx_ready.
//    tx_ts_valid never drops without an accept.
//  - On accept:
//    - count saturating-increments (16 bit).
//    - ts_sent_enough goes to 1 the cycle after the count reaches the target, and stays 1 until a new
//      update is taken or reset.
//    - GAP_CYC=0: stay in SEND, valid stays high (back-to-back TSs).
//    - GAP_CYC>0: enter GAP with valid=0 for exactly GAP_CYC cycles, then return to SEND with valid=1.
//  - Update during SEND/GAP:
//    - Taken only at a TS boundary: the accept cycle, any GAP cycle, or SEND with valid=0.
//    - When taken: ack pulse next cycle, new tx_ts, count cleared.
//    - An accept in the same cycle is not counted for the new context.
//  - ts_stop:
//    - At the next TS boundary go to IDLE with valid=0; a pending TS is still delivered first.
//    - Count and ts_sent_enough are held, not cleared.
//    - Stop and update in the same cycle: stop wins. Update stays pending (level) and is acked from IDLE
//      one cycle later.
//  - ts_update_ack never asserts on consecutive cycles. A new request needs ts_update to drop for >=1 cycle
//    after the ack.
//  - Reset asserted mid-TS: outputs clear immediately; the partial TS is discarded.
// TESTING
//  1. Poll.Active, tx_ready=1, GAP_CYC=0.
//     - Update at N: ack and valid at N+1.
//     - tx_ts={8'hBC,8'hF7,8'hF7,8'hFF,{2'b00,RATE},8'h00,{10{8'h4A}}}.
//     - ts_sent_enough rises one cycle after the 1024th accept.
//  2. Backpressure: tx_ready toggles 1/0/0/1.
//     - valid and tx_ts stay stable while tx_ready=0.
//     - count increments only on accept cycles; 16 TS2 accepts -> ts_sent_enough=1.
//  3. GAP_CYC=3: valid pattern is 1,0,0,0,1 around each accept; the count is unaffected by gaps.
//  4. Update to POLL_CFG while valid=1 and tx_ready=0.
//     - No ack until the TS is accepted; ack next cycle.
//     - tx_ts switches to sym6..15=8'h45; count restarts from 0; ts_sent_enough cleared.
//  5. ts_stop and ts_update in the same cycle at a boundary.
//     - Goes IDLE with valid=0; ack arrives one cycle later.
//     - A non-POLL ts_info is acked with valid staying 0.
//  6. Async rst asserted mid-SEND between clock edges.
//     - All outputs 0 before the next edge.
//     - After release with no update: stays IDLE, valid=0.

Source files
------------

// File: rtl/tsg_if.sv
// Handshake bundle between the LTSSM controller / TX lane and the training-sequence generator.
// The controller side drives the master modport; tsg connects through the slave modport.
interface tsg_if;
    logic [7:0]   ts_info;
    logic         ts_update;
    logic         ts_update_ack;
    logic         ts_stop;
    logic         tx_ready;
    logic         tx_ts_valid;
    logic [127:0] tx_ts;
    logic         ts_sent_enough;

    modport master (
        output ts_info, ts_update, ts_stop, tx_ready,
        input  ts_update_ack, tx_ts_valid, tx_ts, ts_sent_enough
    );

    modport slave (
        input  ts_info, ts_update, ts_stop, tx_ready,
        output ts_update_ack, tx_ts_valid, tx_ts, ts_sent_enough
    );
endinterface

// File: rtl/tsg.sv
// Training-sequence generator: builds Polling TS1/TS2 ordered sets and streams them on a
// valid/ready interface, counting accepted TSs against a per-context target.
module tsg #(
    parameter int TS1_TARGET = 1024,
    parameter int TS2_TARGET = 16,
    parameter int GAP_CYC    = 0
) (
    input  logic  clk,
    input  logic  rst,
    tsg_if.slave  bus
);
    localparam logic [7:0] COM          = 8'hBC;
    localparam logic [7:0] PADG12       = 8'hF7;
    localparam logic [7:0] D10_2        = 8'h4A;
    localparam logic [7:0] D5_2         = 8'h45;
    localparam logic [3:0] POLL         = 4'h2;
    localparam logic [3:0] POLL_ACTIVE  = 4'h0;
    localparam logic [5:0] RATE_SUPPORT = 6'b000010;

    localparam logic [15:0] TS1_TGT  = 16'(TS1_TARGET);
    localparam logic [15:0] TS2_TGT  = 16'(TS2_TARGET);
    localparam logic [15:0] GAP_LOAD = 16'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t         state_q, state_d;
    logic [127:0]   ts_q, ts_d;
    logic           vld_q, vld_d;
    logic           ack_q, ack_d;
    logic           enough_q, enough_d;
    logic           ts1_q, ts1_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    gap_q, gap_d;

    logic           accept;
    logic           boundary;
    logic           take_upd;
    logic [15:0]    cnt_inc;
    logic [15:0]    target;

    function automatic logic [127:0] build_ts(input logic [3:0] sub);
        logic [7:0] id;
        id = (sub == POLL_ACTIVE) ? D10_2 : D5_2;
        return {COM, PADG12, PADG12, 8'hFF, {2'b00, RATE_SUPPORT}, 8'h00, {10{id}}};
    endfunction

    assign accept   = vld_q & bus.tx_ready;
    assign boundary = (state_q == GAP) || ((state_q == SEND) && (!vld_q || accept));
    // Stop beats a simultaneous update; the level request is then honoured from IDLE.
    assign take_upd = bus.ts_update && !ack_q &&
                      ((state_q == IDLE) || (boundary && !bus.ts_stop));
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign target   = ts1_q ? TS1_TGT : TS2_TGT;

    always_comb begin
        state_d  = state_q;
        ts_d     = ts_q;
        vld_d    = vld_q;
        ack_d    = 1'b0;
        enough_d = enough_q;
        ts1_d    = ts1_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;

        case (state_q)
            SEND: begin
                if (accept) begin
                    cnt_d    = cnt_inc;
                    enough_d = enough_q | (cnt_inc >= target);
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        vld_d   = 1'b0;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = SEND;
                    vld_d   = 1'b1;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: ;
        endcase

        if ((state_q != IDLE) && boundary && bus.ts_stop) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end

        // A newly taken context discards any count from an accept in the same cycle.
        if (take_upd) begin
            ack_d    = 1'b1;
            cnt_d    = 16'd0;
            enough_d = 1'b0;
            ts_d     = build_ts(bus.ts_info[3:0]);
            ts1_d    = (bus.ts_info[3:0] == POLL_ACTIVE);
            if (bus.ts_info[7:4] == POLL) begin
                state_d = SEND;
                vld_d   = 1'b1;
            end else begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            vld_q    <= 1'b0;
            ack_q    <= 1'b0;
            enough_q <= 1'b0;
            ts1_q    <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            vld_q    <= vld_d;
            ack_q    <= ack_d;
            enough_q <= enough_d;
            ts1_q    <= ts1_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign bus.tx_ts          = ts_q;
    assign bus.tx_ts_valid    = vld_q;
    assign bus.ts_update_ack  = ack_q;
    assign bus.ts_sent_enough = enough_q;
endmodule
